// File: rtl/string_hw_pkg.sv
// Shared types and helpers for the byte-serial string engine.
// Byte k lives in word k/4, most significant byte first.
package string_hw_pkg;

    localparam int MAX_WORDS = 2;
    localparam int NUM_BYTES = 4 * MAX_WORDS;
    localparam int LEN_BITS  = $clog2(4 * MAX_WORDS + 1);

    typedef logic [0:MAX_WORDS-1][31:0] words_t;

    typedef enum logic [1:0] {
        OP_CMP   = 2'd0,
        OP_UPPER = 2'd1,
        OP_LOWER = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Compare-equal result: word 0 holds 1, all other words zero.
    localparam words_t CMP_EQUAL = words_t'({32'd1, {(32*(MAX_WORDS-1)){1'b0}}});

    function automatic logic [7:0] get_byte(input words_t w, input logic [LEN_BITS-1:0] k);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (k == LEN_BITS'(i)) r = w[i/4][8*(3-i%4) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/string_hw_core_if.sv
// Control/data bundle between the register wrapper (master) and the engine (slave).
interface string_hw_core_if;
    import string_hw_pkg::*;

    logic                go;
    op_e                 op;
    logic [LEN_BITS-1:0] len;
    words_t              a_in;
    words_t              b_in;
    words_t              result;
    logic                done;
    logic                busy;

    modport master (
        output go, op, len, a_in, b_in,
        input  result, done, busy
    );

    modport slave (
        input  go, op, len, a_in, b_in,
        output result, done, busy
    );
endinterface

// File: rtl/string_hw_byte_alu.sv
// Per-byte datapath: case conversion and compare mismatch flag.
module string_hw_byte_alu
    import string_hw_pkg::*;
(
    input  logic [7:0] a_byte,
    input  logic [7:0] b_byte,
    input  op_e        op,
    output logic [7:0] out_byte,
    output logic       mismatch
);

    always_comb begin
        out_byte = a_byte;
        mismatch = 1'b0;
        case (op)
            OP_CMP:   mismatch = (a_byte != b_byte);
            OP_UPPER: if (a_byte >= 8'h61 && a_byte <= 8'h7A) out_byte = a_byte - 8'h20;
            OP_LOWER: if (a_byte >= 8'h41 && a_byte <= 8'h5A) out_byte = a_byte + 8'h20;
            default:  ;
        endcase
    end

endmodule

// File: rtl/string_hw_core.sv
// Byte-serial string engine: compare / to_upper / to_lower, one byte per clock.
// Operands are latched at start, so the wrapper may change its registers mid-run.
module string_hw_core
    import string_hw_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    string_hw_core_if.slave bus
);

    state_e              state_reg;
    op_e                 op_reg;
    logic [LEN_BITS-1:0] cnt_reg;
    logic [LEN_BITS-1:0] n_reg;
    words_t              a_reg;
    words_t              b_reg;
    words_t              result_reg;
    words_t              result_next;
    logic                done_reg;
    logic                busy_reg;

    logic [7:0]          a_byte;
    logic [7:0]          b_byte;
    logic [7:0]          alu_byte;
    logic                mismatch;
    logic                last_byte;
    logic                run_end;
    logic [LEN_BITS-1:0] eff_len;
    logic [7:0]          upd_bytes [NUM_BYTES];

    // Zero or oversize length means the whole operand.
    assign eff_len = (bus.len == '0 || bus.len > LEN_BITS'(NUM_BYTES))
                   ? LEN_BITS'(NUM_BYTES) : bus.len;

    assign a_byte    = get_byte(a_reg, cnt_reg);
    assign b_byte    = get_byte(b_reg, cnt_reg);
    assign last_byte = (cnt_reg == n_reg - LEN_BITS'(1));
    assign run_end   = (op_reg == OP_RSVD) || last_byte || (op_reg == OP_CMP && mismatch);

    string_hw_byte_alu u_alu (
        .a_byte   (a_byte),
        .b_byte   (b_byte),
        .op       (op_reg),
        .out_byte (alu_byte),
        .mismatch (mismatch)
    );

    // Only the byte at the current counter position takes the ALU output.
    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
            assign upd_bytes[gi] = (cnt_reg == LEN_BITS'(gi))
                                 ? alu_byte : result_reg[gi/4][8*(3-gi%4) +: 8];
        end
    endgenerate

    always_comb begin
        result_next = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            result_next[i/4][8*(3-i%4) +: 8] = upd_bytes[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            op_reg     <= OP_CMP;
            cnt_reg    <= '0;
            n_reg      <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.go) begin
                        a_reg      <= bus.a_in;
                        b_reg      <= bus.b_in;
                        op_reg     <= bus.op;
                        n_reg      <= eff_len;
                        cnt_reg    <= '0;
                        result_reg <= (bus.op == OP_UPPER || bus.op == OP_LOWER) ? bus.a_in : '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    cnt_reg <= cnt_reg + LEN_BITS'(1);
                    case (op_reg)
                        OP_CMP: begin
                            if (mismatch)       result_reg <= '0;
                            else if (last_byte) result_reg <= CMP_EQUAL;
                        end
                        OP_UPPER, OP_LOWER: result_reg <= result_next;
                        default:            result_reg <= '0;
                    endcase
                    if (run_end) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    // Held-high go parks here; a low level is needed to rearm.
                    if (!bus.go) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result = result_reg;
    assign bus.done   = done_reg;
    assign bus.busy   = busy_reg;

endmodule
